vote_logger: RTL and testbench
==============================

// Module: vote_logger
// PURPOSE
//  Voting-side front end of the voting machine: qualifies raw candidate button presses,
//  accepts exactly one vote per press, and keeps one saturating tally per candidate.
//  Supplies candi1..4_votes and the casted_vote acknowledge to the result/display
//  selector, which reads the tallies in result mode (mode=1).
// PARAMETERS
//  VOTE_W          8   tally width per candidate; saturates at 2^VOTE_W-1
//  DEBOUNCE_CYCLES 16  consecutive stable-high samples needed to qualify a press (>=2)
//  ACK_CYCLES      8   cycles casted_vote stays high after a vote is committed (>=1)
// PORTS
//  clock          in   1       system clock, all logic on posedge
//  reset          in   1       synchronous, active-high
//  mode           in   1       0 = voting (tallies may change), 1 = result (tallies frozen)
//  candi1_button  in   1       raw candidate 1 button, level, unsynchronised
//  candi2_button  in   1       raw candidate 2 button
//  candi3_button  in   1       raw candidate 3 button
//  candi4_button  in   1       raw candidate 4 button
//  candi1_votes   out  VOTE_W  candidate 1 tally, registered
//  candi2_votes   out  VOTE_W  candidate 2 tally
//  candi3_votes   out  VOTE_W  candidate 3 tally
//  candi4_votes   out  VOTE_W  candidate 4 tally
//  casted_vote    out  1       high for ACK_CYCLES cycles after each committed vote
//  total_votes    out  VOTE_W+2  sum of accepted votes (only with VOTE_TOTAL_EN)
// BEHAVIOUR
//  - Reset: all tallies 0, casted_vote 0, total_votes 0, FSM IDLE, counters 0.
//  - Buttons pass through a 2-flop synchroniser; "btn" below = synchronised vector.
//  - FSM: IDLE, ARM, CAST, ACK, WAIT_REL.
//  - IDLE: mode=0 and btn one-hot -> ARM, latch index, qual_cnt<=0. btn=0, >1 bit,
//    or mode=1 -> stay IDLE.
//  - ARM: btn == latched one-hot and mode=0 -> qual_cnt++; at qual_cnt==DEBOUNCE_CYCLES-1 -> CAST.
//    Any other btn pattern (release, second button) or mode=1 -> IDLE, no vote.
//  - CAST: 1 cycle; latched tally +1 unless already all-ones (saturate, stays max);
//    -> ACK with ack_cnt<=0. A vote reaching CAST always commits, even if mode flips.
//  - ACK: casted_vote=1; ack_cnt++; at ACK_CYCLES-1 -> WAIT_REL.
//  - WAIT_REL: casted_vote=0; stay until btn==0 for one sample -> IDLE.
//    Holding a button forever yields exactly one vote.
//  - casted_vote is registered: high exactly ACK_CYCLES cycles, starting the cycle after CAST.
//  - Latency: raw press stable from edge 0 -> tally visible after edge DEBOUNCE_CYCLES+3
//    (2 sync + 1 IDLE->ARM + DEBOUNCE_CYCLES-1 in ARM + 1 CAST).
//  - Simultaneous buttons never vote; a press during ACK/WAIT_REL is ignored.
//  - mode=1: tallies never change except for a commit already in CAST.
//  - Reset mid-operation: everything back to reset values, any pending vote is lost.
// CONFIGURATION
//  VOTE_TOTAL_EN defined: total_votes port exists. It increments in CAST only when the
//    candidate tally actually increments, so total always equals the sum of the tallies.
//  Not defined: total_votes port and its adder are absent; all other behaviour is identical.
// STRUCTURE
//  vote_pkg: NUM_CANDI=4, state enum {IDLE,ARM,CAST,ACK,WAIT_REL}, candidate index type,
//    and the saturating-increment function.
//  Sub-module: press_qualifier. It holds the synchroniser, the one-hot check and qual_cnt,
//    and emits a 1-cycle press_ok with a 2-bit index.
//  vote_logger top holds the FSM, the tallies, ACK timing and the optional total.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, ACK_CYCLES=3, VOTE_W=8)
//  1 mode=0, candi2 held 20 cycles -> candi2_votes 0->1 after edge 7, casted_vote high 3 cycles,
//    other tallies 0.
//  2 candi3 high for 2 cycles then low (glitch) -> no tally change, casted_vote stays 0.
//  3 candi1+candi4 pressed together 10 cycles -> no vote. Then candi4 alone -> candi4_votes=1.
//  4 candi1_votes preloaded to 255 by 255 presses, one more press -> stays 255,
//    casted_vote pulses; total_votes=255 with VOTE_TOTAL_EN.
//  5 mode=1 while candi2 held -> no vote. mode 0->1 while in CAST -> vote commits (+1).
//  6 reset asserted during ARM and during ACK -> all outputs 0 the next cycle, no vote counted.

Source files
------------

// File: rtl/vote_pkg.sv
// vote_pkg: shared types and helpers for the vote_logger block.
//   NUM_CANDI   number of candidate buttons / tallies
//   MAX_VOTE_W  widest tally the saturating-increment helper supports
//   state_t     vote FSM encoding
//   candi_idx_t candidate index (0 = candidate 1)
package vote_pkg;

   localparam int NUM_CANDI  = 4;
   localparam int MAX_VOTE_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      CAST,
      ACK,
      WAIT_REL
   } state_t;

   typedef logic [1:0] candi_idx_t;

   // Increment a w-bit value held in the low bits of v; an all-ones value stays put.
   function automatic logic [MAX_VOTE_W-1:0] sat_inc(input logic [MAX_VOTE_W-1:0] v,
                                                     input int unsigned w);
      logic [MAX_VOTE_W-1:0] max_v;
      max_v = '1 >> (MAX_VOTE_W - w);
      return (v == max_v) ? v : v + MAX_VOTE_W'(1);
   endfunction

endpackage

// File: rtl/vote_logger_press_qualifier.sv
// press_qualifier: synchronises the raw candidate buttons and qualifies a single
// stable one-hot press for the vote FSM.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   mode               0 = voting, 1 = result (no press may start or continue)
//   buttons            raw button levels, candidate 1 in bit 0
//   in_idle, in_arm    FSM is in IDLE / ARM
//   start              a new one-hot press may begin (used in IDLE)
//   hold               synchronised buttons still equal the latched press
//   released           no button pressed (synchronised)
//   press_ok           1-cycle pulse: press held for DEBOUNCE_CYCLES ARM cycles
//   index              latched candidate index
module press_qualifier
   import vote_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 mode,
   input  logic [NUM_CANDI-1:0] buttons,
   input  logic                 in_idle,
   input  logic                 in_arm,
   output logic                 start,
   output logic                 hold,
   output logic                 released,
   output logic                 press_ok,
   output candi_idx_t           index
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [NUM_CANDI-1:0] sync_meta;
   logic [NUM_CANDI-1:0] btn;
   logic [NUM_CANDI-1:0] latched_oh;
   logic [CNT_W-1:0]     qual_cnt;
   candi_idx_t           enc_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_meta <= '0;
         btn       <= '0;
      end else begin
         sync_meta <= buttons;
         btn       <= sync_meta;
      end
   end

   always_comb begin
      enc_idx = '0;
      for (int i = 0; i < NUM_CANDI; i++) begin
         if (btn[i]) enc_idx = candi_idx_t'(i);
      end
   end

   assign start    = !mode && $onehot(btn);
   assign hold     = !mode && (btn == latched_oh);
   assign released = (btn == '0);
   assign press_ok = in_arm && hold && (qual_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         latched_oh <= '0;
         index      <= '0;
         qual_cnt   <= '0;
      end else if (in_idle) begin
         qual_cnt <= '0;
         if (start) begin
            latched_oh <= btn;
            index      <= enc_idx;
         end
      end else if (in_arm && hold) begin
         qual_cnt <= qual_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vote_logger.sv
// vote_logger: voting front end. Qualifies candidate presses, commits one vote per
// press into a saturating per-candidate tally and pulses casted_vote afterwards.
// Optional feature macro: VOTE_TOTAL_EN adds the total_votes output.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   mode                  0 = voting, 1 = result (tallies frozen)
//   candi1..4_button      raw candidate buttons
//   candi1..4_votes       registered tallies
//   casted_vote           high ACK_CYCLES cycles after each committed vote
//   total_votes           sum of tallies (VOTE_TOTAL_EN only)
//
// state    | meaning
// IDLE     | waiting for a single button in voting mode
// ARM      | same button must stay held for DEBOUNCE_CYCLES cycles
// CAST     | commit the vote into the latched candidate's tally
// ACK      | casted_vote high, counting ACK_CYCLES
// WAIT_REL | wait for all buttons released before the next vote
module vote_logger
   import vote_pkg::*;
#(
   parameter int VOTE_W          = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ACK_CYCLES      = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode,
   input  logic              candi1_button,
   input  logic              candi2_button,
   input  logic              candi3_button,
   input  logic              candi4_button,
   output logic [VOTE_W-1:0] candi1_votes,
   output logic [VOTE_W-1:0] candi2_votes,
   output logic [VOTE_W-1:0] candi3_votes,
   output logic [VOTE_W-1:0] candi4_votes,
   output logic              casted_vote
`ifdef VOTE_TOTAL_EN
   ,output logic [VOTE_W+1:0] total_votes
`endif
);

   localparam int ACK_W = (ACK_CYCLES > 2) ? $clog2(ACK_CYCLES) : 1;

   state_t            state, next_state;
   logic [ACK_W-1:0]  ack_cnt;
   logic [VOTE_W-1:0] tally [NUM_CANDI];
   logic              q_start, q_hold, q_released, q_press_ok;
   candi_idx_t        q_index;
   logic              cast_en, ack_next, at_max;

   press_qualifier #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_qual (
      .clock    (clock),
      .reset    (reset),
      .mode     (mode),
      .buttons  ({candi4_button, candi3_button, candi2_button, candi1_button}),
      .in_idle  (state == IDLE),
      .in_arm   (state == ARM),
      .start    (q_start),
      .hold     (q_hold),
      .released (q_released),
      .press_ok (q_press_ok),
      .index    (q_index)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (q_start) next_state = ARM;
         ARM: begin
            if (q_press_ok)   next_state = CAST;
            else if (!q_hold) next_state = IDLE;
         end
         CAST:     next_state = ACK;
         ACK:      if (ack_cnt == ACK_W'(ACK_CYCLES - 1)) next_state = WAIT_REL;
         WAIT_REL: if (q_released) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Mode is deliberately ignored here: a vote that reached CAST always commits.
   always_comb begin
      cast_en  = (state == CAST);
      ack_next = (next_state == ACK);
      at_max   = &tally[q_index];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ack_cnt     <= '0;
         casted_vote <= 1'b0;
      end else begin
         casted_vote <= ack_next;
         if (cast_en)           ack_cnt <= '0;
         else if (state == ACK) ack_cnt <= ack_cnt + ACK_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CANDI; i++) tally[i] <= '0;
      end else if (cast_en) begin
         tally[q_index] <= VOTE_W'(sat_inc(MAX_VOTE_W'(tally[q_index]), VOTE_W));
      end
   end

   assign candi1_votes = tally[0];
   assign candi2_votes = tally[1];
   assign candi3_votes = tally[2];
   assign candi4_votes = tally[3];

`ifdef VOTE_TOTAL_EN
   localparam int TOT_W = VOTE_W + 2;

   // Only counts votes that actually moved a tally, so it tracks the tally sum.
   always_ff @(posedge clock) begin
      if (reset)                  total_votes <= '0;
      else if (cast_en && !at_max) total_votes <= total_votes + TOT_W'(1);
   end
`endif

endmodule

// File: tb/tb_vote_logger.sv
module tb_vote_logger;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mode  = 1'b0;
   logic       candi1_button = 1'b0;
   logic       candi2_button = 1'b0;
   logic       candi3_button = 1'b0;
   logic       candi4_button = 1'b0;
   logic [7:0] candi1_votes, candi2_votes, candi3_votes, candi4_votes;
   logic       casted_vote;
`ifdef VOTE_TOTAL_EN
   logic [9:0] total_votes;
`endif

   int total = 0;
   int bad   = 0;
   logic cv_seen;

   vote_logger #(
      .VOTE_W(8),
      .DEBOUNCE_CYCLES(4),
      .ACK_CYCLES(3)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mode          (mode),
      .candi1_button (candi1_button),
      .candi2_button (candi2_button),
      .candi3_button (candi3_button),
      .candi4_button (candi4_button),
      .candi1_votes  (candi1_votes),
      .candi2_votes  (candi2_votes),
      .candi3_votes  (candi3_votes),
      .candi4_votes  (candi4_votes),
      .casted_vote   (casted_vote)
`ifdef VOTE_TOTAL_EN
      ,.total_votes  (total_votes)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (casted_vote === 1'b1) cv_seen = 1'b1;
      end
   endtask

   task automatic release_all();
      candi1_button = 1'b0;
      candi2_button = 1'b0;
      candi3_button = 1'b0;
      candi4_button = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      release_all();
      tick(3);
      reset = 1'b0;
      total++;
      if ({candi1_votes, candi2_votes, candi3_votes, candi4_votes} !== 32'h0) begin
         bad++;
         $display("FAIL reset_tallies got=%h want=0", {candi1_votes, candi2_votes, candi3_votes, candi4_votes});
      end
      total++;
      if (casted_vote !== 1'b0) begin
         bad++;
         $display("FAIL reset_casted got=%b want=0", casted_vote);
      end
`ifdef VOTE_TOTAL_EN
      total++;
      if (total_votes !== 10'd0) begin
         bad++;
         $display("FAIL reset_total got=%0d want=0", total_votes);
      end
`endif
   endtask

   // candi2 held 20 cycles: tally visible after edge 7, ack high after edges 7,8,9
   task automatic test_single_vote();
      candi2_button = 1'b1;
      tick(7);
      total++;
      if (candi2_votes !== 8'd0 || casted_vote !== 1'b0) begin
         bad++;
         $display("FAIL single_before got votes=%0d cv=%b want votes=0 cv=0", candi2_votes, casted_vote);
      end
      for (int k = 0; k < 3; k++) begin
         tick(1);
         total++;
         if (candi2_votes !== 8'd1 || casted_vote !== 1'b1) begin
            bad++;
            $display("FAIL single_ack%0d got votes=%0d cv=%b want votes=1 cv=1", k, candi2_votes, casted_vote);
         end
      end
      tick(1);
      total++;
      if (casted_vote !== 1'b0) begin
         bad++;
         $display("FAIL single_ack_end got cv=%b want 0", casted_vote);
      end
      tick(9);
      total++;
      if (candi2_votes !== 8'd1) begin
         bad++;
         $display("FAIL single_held got votes=%0d want 1", candi2_votes);
      end
      total++;
      if ({candi1_votes, candi3_votes, candi4_votes} !== 24'h0) begin
         bad++;
         $display("FAIL single_others got=%h want=0", {candi1_votes, candi3_votes, candi4_votes});
      end
      release_all();
      tick(4);
   endtask

   task automatic test_glitch();
      cv_seen = 1'b0;
      candi3_button = 1'b1;
      tick(2);
      candi3_button = 1'b0;
      tick(15);
      total++;
      if (candi3_votes !== 8'd0) begin
         bad++;
         $display("FAIL glitch_tally got=%0d want 0", candi3_votes);
      end
      total++;
      if (cv_seen !== 1'b0) begin
         bad++;
         $display("FAIL glitch_casted got pulse=%b want 0", cv_seen);
      end
   endtask

   task automatic test_simultaneous();
      cv_seen = 1'b0;
      candi1_button = 1'b1;
      candi4_button = 1'b1;
      tick(10);
      release_all();
      tick(4);
      total++;
      if (candi1_votes !== 8'd0 || candi4_votes !== 8'd0 || cv_seen !== 1'b0) begin
         bad++;
         $display("FAIL simul_novote got c1=%0d c4=%0d pulse=%b want 0 0 0", candi1_votes, candi4_votes, cv_seen);
      end
      candi4_button = 1'b1;
      tick(12);
      total++;
      if (candi4_votes !== 8'd1 || candi1_votes !== 8'd0) begin
         bad++;
         $display("FAIL simul_single got c4=%0d c1=%0d want 1 0", candi4_votes, candi1_votes);
      end
      release_all();
      tick(4);
   endtask

   task automatic press_candi1();
      candi1_button = 1'b1;
      tick(10);
      candi1_button = 1'b0;
      tick(4);
   endtask

   task automatic test_saturation();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      for (int p = 0; p < 255; p++) press_candi1();
      total++;
      if (candi1_votes !== 8'd255) begin
         bad++;
         $display("FAIL sat_preload got=%0d want 255", candi1_votes);
      end
      cv_seen = 1'b0;
      press_candi1();
      total++;
      if (candi1_votes !== 8'd255) begin
         bad++;
         $display("FAIL sat_hold got=%0d want 255", candi1_votes);
      end
      total++;
      if (cv_seen !== 1'b1) begin
         bad++;
         $display("FAIL sat_casted got pulse=%b want 1", cv_seen);
      end
`ifdef VOTE_TOTAL_EN
      total++;
      if (total_votes !== 10'd255) begin
         bad++;
         $display("FAIL sat_total got=%0d want 255", total_votes);
      end
`endif
   endtask

   task automatic test_mode();
      cv_seen = 1'b0;
      mode = 1'b1;
      candi2_button = 1'b1;
      tick(15);
      release_all();
      tick(4);
      total++;
      if (candi2_votes !== 8'd0 || cv_seen !== 1'b0) begin
         bad++;
         $display("FAIL mode_frozen got votes=%0d pulse=%b want 0 0", candi2_votes, cv_seen);
      end
      mode = 1'b0;
      candi2_button = 1'b1;
      tick(7);
      mode = 1'b1;
      tick(1);
      total++;
      if (candi2_votes !== 8'd1 || casted_vote !== 1'b1) begin
         bad++;
         $display("FAIL mode_cast_commit got votes=%0d cv=%b want 1 1", candi2_votes, casted_vote);
      end
`ifdef VOTE_TOTAL_EN
      total++;
      if (total_votes !== 10'd256) begin
         bad++;
         $display("FAIL mode_total got=%0d want 256", total_votes);
      end
`endif
      release_all();
      tick(6);
      mode = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      total++;
      if ({candi1_votes, candi2_votes, candi3_votes, candi4_votes} !== 32'h0 || casted_vote !== 1'b0) begin
         bad++;
         $display("FAIL %s got tallies=%h cv=%b want 0 0", tag,
                  {candi1_votes, candi2_votes, candi3_votes, candi4_votes}, casted_vote);
      end
`ifdef VOTE_TOTAL_EN
      total++;
      if (total_votes !== 10'd0) begin
         bad++;
         $display("FAIL %s_total got=%0d want 0", tag, total_votes);
      end
`endif
   endtask

   task automatic test_reset_mid();
      candi3_button = 1'b1;
      tick(4);
      reset = 1'b1;
      candi3_button = 1'b0;
      tick(1);
      check_all_zero("rst_arm");
      reset = 1'b0;
      cv_seen = 1'b0;
      tick(12);
      total++;
      if (candi3_votes !== 8'd0 || cv_seen !== 1'b0) begin
         bad++;
         $display("FAIL rst_arm_novote got votes=%0d pulse=%b want 0 0", candi3_votes, cv_seen);
      end
      candi3_button = 1'b1;
      tick(8);
      total++;
      if (casted_vote !== 1'b1) begin
         bad++;
         $display("FAIL rst_ack_setup got cv=%b want 1", casted_vote);
      end
      reset = 1'b1;
      candi3_button = 1'b0;
      tick(1);
      check_all_zero("rst_ack");
      reset = 1'b0;
      cv_seen = 1'b0;
      tick(10);
      check_all_zero("rst_ack_after");
      total++;
      if (cv_seen !== 1'b0) begin
         bad++;
         $display("FAIL rst_ack_pulse got=%b want 0", cv_seen);
      end
   endtask

   initial begin
      cv_seen = 1'b0;
      test_reset();
      test_single_vote();
      test_glitch();
      test_simultaneous();
      test_saturation();
      test_mode();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
